// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div : multi-cycle radix-2 restoring integer divider (execute stage)
//
// Purpose
//   Divides A by B and produces one quotient bit per clock. Signed division
//   truncates toward zero, and the remainder takes the sign of the dividend.
//   A divide by zero returns Q=R=0 and raises div_zero. The controller stalls
//   on busy and collects the result on the single-cycle done pulse.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 4)
//   CNT_W     iteration counter width, derived from WIDTH (leave at default)
//
// Ports
//   clk        in   rising-edge system clock
//   rst        in   asynchronous active-high reset (aborts any running op)
//   start      in   operation request, sampled only while idle
//   sign_flag  in   1 = two's complement divide, 0 = unsigned; sampled with start
//   A          in   dividend, sampled with start
//   B          in   divisor, sampled with start
//   busy       out  high from the start edge until the result edge
//   done       out  one-cycle pulse; Q/R/div_zero valid from this cycle on
//   Q          out  quotient, held until the next done
//   R          out  remainder, held until the next done
//   div_zero   out  1 if the last completed operation had B == 0
//
// Timing (start sampled at edge k)
//   B != 0 : WIDTH CALC edges, then one FIX edge -> done after edge k+WIDTH+1
//   B == 0 : straight to FIX                     -> done after edge k+1
// -----------------------------------------------------------------------------
module seq_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign_flag,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(WIDTH);

    // Two's complement negation. The most negative value maps onto itself,
    // which read as unsigned is exactly 2^(WIDTH-1), so no magnitude is lost.
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        twos_neg = (~v) + ONE_W;
    endfunction

    // Magnitude of an operand: negate only when it is a negative signed value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             neg);
        if (neg) begin
            magnitude = twos_neg(v);
        end else begin
            magnitude = v;
        end
    endfunction

    // ---------------------------------------------------------------------
    // State and work registers
    // ---------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [WIDTH-1:0] r_quo;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_divisor;  // |B|
    logic             r_signed;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_zero_op;

    // ---------------------------------------------------------------------
    // Combinational datapath
    // ---------------------------------------------------------------------
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;

    logic             w_carry;    // bit WIDTH of the shifted remainder
    logic [WIDTH-1:0] w_low;      // bits WIDTH-1:0 of the shifted remainder
    logic             w_borrow;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Operand sign detection and magnitude capture for the start edge.
    always_comb begin
        w_a_neg  = sign_flag & A[WIDTH-1];
        w_b_neg  = sign_flag & B[WIDTH-1];
        w_a_mag  = magnitude(A, w_a_neg);
        w_b_mag  = magnitude(B, w_b_neg);
        w_b_zero = (B == ZERO_W);
    end

    // One restoring step. The shifted remainder is WIDTH+1 bits wide,
    // {w_carry, w_low}. Because rem < |B| before the shift, a set w_carry
    // already means the shifted value exceeds |B|; otherwise the borrow of
    // w_low - |B| decides. In both accepting cases the true difference is
    // below |B| and therefore fits in w_diff.
    always_comb begin
        w_carry              = r_rem[WIDTH-1];
        w_low                = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
        {w_borrow, w_diff}   = {1'b0, w_low} - {1'b0, r_divisor};
        w_ge                 = w_carry | ~w_borrow;
        w_quo_next           = {r_quo[WIDTH-2:0], w_ge};
        if (w_ge) begin
            w_rem_next = w_diff;
        end else begin
            w_rem_next = w_low;
        end
    end

    // Sign correction of the raw magnitude results for the FIX edge.
    always_comb begin
        if (r_signed & (r_sign_a ^ r_sign_b)) begin
            w_q_fix = twos_neg(r_quo);
        end else begin
            w_q_fix = r_quo;
        end
        if (r_signed & r_sign_a) begin
            w_r_fix = twos_neg(r_rem);
        end else begin
            w_r_fix = r_rem;
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered handshake and result outputs
    // ---------------------------------------------------------------------
    // Sequencer: IDLE accepts start, CALC iterates WIDTH times, FIX publishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= ZERO_C;
            r_rem     <= ZERO_W;
            r_quo     <= ZERO_W;
            r_divisor <= ZERO_W;
            r_signed  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_zero_op <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Q         <= ZERO_W;
            R         <= ZERO_W;
            div_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_signed  <= sign_flag;
                        r_sign_a  <= w_a_neg;
                        r_sign_b  <= w_b_neg;
                        r_quo     <= w_a_mag;
                        r_rem     <= ZERO_W;
                        r_divisor <= w_b_mag;
                        r_cnt     <= ITERS_C;
                        busy      <= 1'b1;
                        if (w_b_zero) begin
                            r_zero_op <= 1'b1;
                            r_state   <= ST_FIX;
                        end else begin
                            r_zero_op <= 1'b0;
                            r_state   <= ST_CALC;
                        end
                    end else begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_CALC: begin
                    done  <= 1'b0;
                    busy  <= 1'b1;
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - ONE_C;
                    // Counter started at WIDTH, so the edge that takes it
                    // to zero is the WIDTH-th CALC edge.
                    if (r_cnt == ONE_C) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_state <= ST_CALC;
                    end
                end

                ST_FIX: begin
                    if (r_zero_op) begin
                        Q        <= ZERO_W;
                        R        <= ZERO_W;
                        div_zero <= 1'b1;
                    end else begin
                        Q        <= w_q_fix;
                        R        <= w_r_fix;
                        div_zero <= 1'b0;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// -----------------------------------------------------------------------------
// tb_seq_div : directed self-checking bench for seq_div (WIDTH = 32)
//
// Each operation is launched on a negedge, the start edge is the following
// posedge, and outputs are sampled 1 time unit after every posedge. Expected
// quotients, remainders and latencies are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_seq_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign_flag;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic [31:0] R;
    logic        div_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_div #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign_flag (sign_flag),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Q         (Q),
        .R         (R),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present operands with start high; the next posedge is the start edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sf);
        A         = a;
        B         = b;
        sign_flag = sf;
        start     = 1'b1;
    endtask

    // Consume the start edge, scramble the inputs, then count edges until done.
    // p1/p2: edge counts after which a stray start pulse is injected (-1 = none).
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [31:0] eq, input logic [31:0] er,
                             input logic edz, input int p1, input int p2);
        int n;
        bit seen;
        bit busy_ok;
        @(posedge clk);
        #1;
        start     = 1'b0;
        A         = 32'hDEADBEEF;
        B         = 32'h00000003;
        sign_flag = ~sign_flag;
        check_eq({tag, "_busy_at_start"}, {31'd0, busy}, 32'd1);
        seen    = 1'b0;
        busy_ok = 1'b1;
        n       = 0;
        while (!seen && n < 100) begin
            if (n == p1 || n == p2) begin
                start = 1'b1;
                A     = 32'h00000001;
                B     = 32'h00000001;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (done) begin
                seen = 1'b1;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
        check_eq({tag, "_latency"}, n, exp_lat);
        check_eq({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_Q"}, Q, eq);
        check_eq({tag, "_R"}, R, er);
        check_eq({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sf, input int exp_lat,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz);
        @(negedge clk);
        launch(a, b, sf);
        wait_done(tag, exp_lat, eq, er, edz, -1, -1);
    endtask

    initial begin
        bit saw_done;
        rst       = 1'b1;
        start     = 1'b0;
        sign_flag = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_Q", Q, 32'd0);
        check_eq("reset_R", R, 32'd0);
        check_eq("reset_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 100 / 7, and done is a single-cycle pulse
        run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);
        check_eq("Q_held", Q, 32'd14);

        // Signed mixed signs and the same bits unsigned
        run_op("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run_op("sdiv_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 33, 32'hFFFFFFFD, 32'd1, 1'b0);
        run_op("udiv_f9_2", 32'hFFFFFFF9, 32'd2, 1'b0, 33, 32'h7FFFFFFC, 32'd1, 1'b0);

        // Divide by zero, both signedness modes, then a normal op clears the flag
        run_op("sdiv_by_zero", 32'h12345678, 32'd0, 1'b1, 1, 32'd0, 32'd0, 1'b1);
        run_op("udiv_by_zero", 32'h12345678, 32'd0, 1'b0, 1, 32'd0, 32'd0, 1'b1);
        run_op("udiv_3_5", 32'd3, 32'd5, 1'b0, 33, 32'd0, 32'd3, 1'b0);

        // Extremes
        run_op("sdiv_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 33, 32'h80000000, 32'd0, 1'b0);
        run_op("udiv_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 33, 32'hFFFFFFFF, 32'd0, 1'b0);

        // Stray start pulses while busy are ignored
        @(negedge clk);
        launch(32'd100, 32'd7, 1'b0);
        wait_done("hs_ignore", 33, 32'd14, 32'd2, 1'b0, 5, 20);

        // Back-to-back start in the done cycle
        launch(32'h80000000, 32'd7, 1'b1);
        wait_done("hs_b2b", 33, 32'hEDB6DB6E, 32'hFFFFFFFE, 1'b0, -1, -1);

        // Reset mid-calculation: outputs drop without a clock edge
        @(negedge clk);
        launch(32'd100, 32'd7, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_Q", Q, 32'd0);
        check_eq("abort_R", R, 32'd0);
        check_eq("abort_div_zero", {31'd0, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) begin
                saw_done = 1'b1;
            end
        end
        check_eq("abort_no_done", {31'd0, saw_done}, 32'd0);

        // Fresh operation after the abort
        run_op("sdiv_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 33, 32'd14, 32'hFFFFFFFE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Multi-cycle, parametrised integer divider for the CPU execute stage.
- Replaces the single-cycle combinational divide path with a radix-2 restoring iteration: one quotient bit per clock.
- Uses a start/busy/done handshake so the pipeline controller can stall while a DIV/DIVU is in flight.
- Keeps the existing arithmetic contract: truncating signed division, remainder sign follows dividend, divide-by-zero yields Q=R=0. Adds an explicit div_zero flag.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- sign_flag  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start.
- A  in  WIDTH  dividend; sampled with start.
- B  in  WIDTH  divisor; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; Q/R/div_zero valid from this cycle on.
- Q  out  WIDTH  quotient, registered, held until next done.
- R  out  WIDTH  remainder, registered, held until next done.
- div_zero  out  1  registered; 1 if the last completed op had B==0.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, Q=0, R=0, div_zero=0; counter and work registers cleared.
  - An aborted operation never produces done.
- States:
  - IDLE
  - CALC
  - FIX
- IDLE, start=1 at edge k:
  - Latch sign_flag, |A|, |B|, and sign bits (magnitudes only when signed and MSB set; else raw).
  - If B==0 go to FIX with zero_op=1; else go to CALC, counter=WIDTH.
  - busy=1 from edge k.
- CALC, each edge:
  - Shift {rem,quo} left by 1.
  - Trial-subtract |B| from rem using WIDTH+1-bit arithmetic.
  - If non-negative, keep the difference and set quo LSB=1.
  - Decrement counter; at the edge where counter reaches 0, go to FIX.
  - Exactly WIDTH edges are spent in CALC.
- FIX, one edge:
  - Q = quo negated if signed and sign(A)≠sign(B).
  - R = rem negated if signed and sign(A)=1.
  - div_zero=0.
  - zero_op: Q=0, R=0, div_zero=1.
  - done=1 and busy=0 for the following cycle; return to IDLE.
- Latency, with start sampled at edge k:
  - Normal: done high in the cycle after edge k+WIDTH+1 (WIDTH+1 edges).
  - B==0: done high after edge k+1.
- Handshake:
  - start while busy=1 is ignored, with no effect on the running op.
  - start may be asserted in the same cycle done=1; since state is IDLE it is accepted back-to-back.
  - Inputs A/B/sign_flag may change freely after the start edge.
- Arithmetic:
  - Results are identical to Verilog signed/unsigned / and % on WIDTH-bit operands.
  - Signed overflow −2^(WIDTH−1) / −1 gives Q=−2^(WIDTH−1) (wrap), R=0, div_zero=0.
  - |A| of the most negative value is handled as unsigned WIDTH-bit 2^(WIDTH−1) and is not truncated.
- Q/R/div_zero change only at the FIX edge or at reset.
- done is never high for more than one consecutive cycle per operation.

Test Plan (WIDTH=32):
- Unsigned: start, sign_flag=0, A=100, B=7 → done exactly 33 edges after start edge; Q=14, R=2, div_zero=0; busy high for the whole interval.
- Signed mixed signs: A=−7 (0xFFFFFFF9), B=2 → Q=−3 (0xFFFFFFFD), R=−1. A=7, B=−2 → Q=−3, R=1. Same bits unsigned: A=0xFFFFFFF9, B=2 → Q=0x7FFFFFFC, R=1.
- Divide-by-zero: A=0x12345678, B=0, either sign_flag → done one edge after start; Q=0, R=0, div_zero=1. The next normal op clears div_zero.
- Overflow/extremes:
  - Signed A=0x80000000, B=0xFFFFFFFF → Q=0x80000000, R=0.
  - Unsigned A=0xFFFFFFFF, B=1 → Q=0xFFFFFFFF, R=0.
  - Unsigned A=3, B=5 → Q=0, R=3.
- Handshake: pulse start again at cycles 5 and 20 of an op → ignored, result unchanged. Assert start with new operands in the done cycle → second op accepted, its done 33 edges later.
- Reset mid-op: assert rst at cycle 10 of CALC → busy/done/Q/R/div_zero drop to 0 immediately (asynchronously), and no done is produced. A new start after rst is released completes correctly.
